// File: rtl/sfr_bus_master.sv
// sfr_bus_master: byte-stream command bridge that issues one SFR bus
// transaction per host command and answers with read data, an ACK byte,
// or an ERR byte for an illegal opcode.
module sfr_bus_master #(
  parameter logic [7:0] ACK_BYTE = 8'h55,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sel,
  output logic [7:0]  addr,
  output logic        r,
  output logic [1:0]  w,
  output logic [15:0] dwrite,
  input  logic [15:0] sfr_data
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_DHI  = 4'd2;
  localparam logic [3:0] S_DLO  = 4'd3;
  localparam logic [3:0] S_BUS  = 4'd4;
  localparam logic [3:0] S_RHI  = 4'd5;
  localparam logic [3:0] S_RLO  = 4'd6;
  localparam logic [3:0] S_ACK  = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic        is_write;
  logic        is_write_nxt;
  logic [1:0]  ww;
  logic [1:0]  ww_nxt;
  logic [15:0] hold;
  logic [15:0] hold_nxt;
  logic [7:0]  addr_nxt;
  logic [15:0] dwrite_nxt;
  logic [7:0]  tx_data_nxt;
  logic        rx_acc;
  logic        tx_acc;
  logic        rx_ready_nxt;
  logic        tx_valid_nxt;
  logic        sel_nxt;
  logic        r_nxt;
  logic [1:0]  w_nxt;

  assign rx_acc = rx_valid & rx_ready;
  assign tx_acc = tx_valid & tx_ready;

  // Command sequencing: next state plus the command fields latched per byte.
  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write;
    ww_nxt       = ww;
    addr_nxt     = addr;
    dwrite_nxt   = dwrite;
    case (state)
      S_IDLE: begin
        if (rx_acc) begin
          if (rx_data == 8'h00) begin
            is_write_nxt = 1'b0;
            state_nxt    = S_ADDR;
          end else if (rx_data[7:2] == 6'b100000) begin
            is_write_nxt = 1'b1;
            ww_nxt       = rx_data[1:0];
            state_nxt    = S_ADDR;
          end else begin
            state_nxt = S_ERR;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_acc) begin
          addr_nxt  = rx_data;
          state_nxt = is_write ? S_DHI : S_BUS;
        end else begin
          state_nxt = S_ADDR;
        end
      end
      S_DHI: begin
        if (rx_acc) begin
          dwrite_nxt[15:8] = rx_data;
          state_nxt        = S_DLO;
        end else begin
          state_nxt = S_DHI;
        end
      end
      S_DLO: begin
        if (rx_acc) begin
          dwrite_nxt[7:0] = rx_data;
          state_nxt       = S_BUS;
        end else begin
          state_nxt = S_DLO;
        end
      end
      S_BUS: begin
        state_nxt = is_write ? S_ACK : S_RHI;
      end
      S_RHI: begin
        if (tx_acc) begin
          state_nxt = S_RLO;
        end else begin
          state_nxt = S_RHI;
        end
      end
      S_RLO, S_ACK, S_ERR: begin
        if (tx_acc) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Read data is captured only at the end of the read bus cycle, so later
  // bus activity cannot disturb the bytes being returned.
  always_comb begin
    if ((state == S_BUS) && !is_write) begin
      hold_nxt = sfr_data;
    end else begin
      hold_nxt = hold;
    end
  end

  // Output values decoded from the upcoming state so every port is a flop.
  always_comb begin
    rx_ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ADDR) ||
                   (state_nxt == S_DHI)  || (state_nxt == S_DLO);
    tx_valid_nxt = (state_nxt == S_RHI) || (state_nxt == S_RLO) ||
                   (state_nxt == S_ACK) || (state_nxt == S_ERR);
    sel_nxt      = (state_nxt == S_BUS);
    r_nxt        = (state_nxt == S_BUS) && !is_write_nxt;
    if ((state_nxt == S_BUS) && is_write_nxt) begin
      w_nxt = ww_nxt;
    end else begin
      w_nxt = 2'b00;
    end
    case (state_nxt)
      S_RHI:   tx_data_nxt = hold_nxt[15:8];
      S_RLO:   tx_data_nxt = hold_nxt[7:0];
      S_ACK:   tx_data_nxt = ACK_BYTE;
      S_ERR:   tx_data_nxt = ERR_BYTE;
      default: tx_data_nxt = tx_data;
    endcase
  end

  // State and registered outputs; reset drops bus strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      ww       <= 2'b00;
      hold     <= 16'h0000;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      sel      <= 1'b0;
      r        <= 1'b0;
      w        <= 2'b00;
      addr     <= 8'h00;
      dwrite   <= 16'h0000;
    end else begin
      state    <= state_nxt;
      is_write <= is_write_nxt;
      ww       <= ww_nxt;
      hold     <= hold_nxt;
      rx_ready <= rx_ready_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      sel      <= sel_nxt;
      r        <= r_nxt;
      w        <= w_nxt;
      addr     <= addr_nxt;
      dwrite   <= dwrite_nxt;
    end
  end

endmodule

// File: tb/tb_sfr_bus_master.sv
// tb_sfr_bus_master: directed scenarios plus randomized commands, checked
// against a command-level reference model (register image + byte queues).
module tb_sfr_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        sel;
  logic [7:0]  addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] sfr_data;

  sfr_bus_master dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sel(sel), .addr(addr), .r(r), .w(w), .dwrite(dwrite),
    .sfr_data(sfr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic        rd;
    logic [1:0]  we;
    logic [7:0]  a;
    logic [15:0] d;
  } bus_ev_t;

  bus_ev_t     bus_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] slave_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] noise = 16'h0000;
  logic        hold_low = 1'b0;
  int          cyc = 0;
  int          last_acc = 0;
  int          first_tx_cyc = -1;
  int          checks = 0;
  int          failures = 0;

  // Slave: real data only during a read strobe, junk otherwise.
  assign sfr_data = (sel && r) ? slave_mem[addr] : noise;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle counter, advanced at each active edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Host-side ready and slave noise, changed just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    noise = 16'($urandom);
    tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor on the inactive edge: bus log, slave writes, tx log, protocol rules.
  initial begin
    logic       prev_v;
    logic       stalled;
    logic [7:0] stall_data;
    prev_v = 1'b0;
    stalled = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (sel) begin
        bus_q.push_back('{cyc, r, w, addr, dwrite});
        if (w[1]) slave_mem[addr][15:8] = dwrite[15:8];
        if (w[0]) slave_mem[addr][7:0] = dwrite[7:0];
      end
      if (stalled && !reset) begin
        check_eq("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        check_eq("tx_hold_data", {24'd0, tx_data}, {24'd0, stall_data});
      end
      stalled = tx_valid && !tx_ready && !reset;
      stall_data = tx_data;
      if (tx_valid) begin
        check_eq("rx_ready_in_resp", {31'd0, rx_ready}, 32'd0);
        check_eq("sel_in_resp", {31'd0, sel}, 32'd0);
      end
      if (tx_valid && !prev_v) first_tx_cyc = cyc;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      prev_v = tx_valid;
    end
  end

  // Offer one byte after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_accept_timeout", {31'd0, rx_ready}, 32'd1);
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // One full command: send bytes, collect response, compare with the model.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] dh,
                        input logic [7:0] dl, input int gap, input int hold);
    logic       is_rd;
    logic       is_wr;
    int         nresp;
    int         n;
    int         exp_first;
    logic [7:0] exp_b [2];
    is_rd = (op == 8'h00);
    is_wr = (op >= 8'h80) && (op <= 8'h83);
    if (is_rd) begin
      nresp = 2;
      exp_b[0] = ref_mem[a][15:8];
      exp_b[1] = ref_mem[a][7:0];
    end else if (is_wr) begin
      nresp = 1;
      exp_b[0] = 8'h55;
      exp_b[1] = 8'h00;
    end else begin
      nresp = 1;
      exp_b[0] = 8'hEE;
      exp_b[1] = 8'h00;
    end
    bus_q.delete();
    tx_q.delete();
    first_tx_cyc = -1;
    if (hold > 0) begin
      hold_low = 1'b1;
      tx_ready = 1'b0;
    end
    send_byte(op, gap);
    if (is_rd || is_wr) send_byte(a, gap);
    if (is_wr) begin
      send_byte(dh, gap);
      send_byte(dl, gap);
    end
    if (hold > 0) begin
      n = 0;
      @(negedge clk);
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      repeat (hold) begin
        @(negedge clk);
        check_eq("bp_valid", {31'd0, tx_valid}, 32'd1);
        check_eq("bp_data", {24'd0, tx_data}, {24'd0, exp_b[0]});
        check_eq("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      hold_low = 1'b0;
      tx_ready = 1'b1;
    end
    n = 0;
    while (tx_q.size() < nresp && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq("resp_count", tx_q.size(), nresp);
    for (int i = 0; i < nresp; i++) begin
      if (i < tx_q.size()) check_eq("resp_byte", {24'd0, tx_q[i]}, {24'd0, exp_b[i]});
    end
    check_eq("bus_count", bus_q.size(), (is_rd || is_wr) ? 1 : 0);
    exp_first = last_acc;
    if (bus_q.size() > 0) begin
      check_eq("bus_latency", bus_q[0].c, last_acc);
      check_eq("bus_r", {31'd0, bus_q[0].rd}, {31'd0, is_rd});
      check_eq("bus_w", {30'd0, bus_q[0].we}, is_wr ? {30'd0, op[1:0]} : 32'd0);
      check_eq("bus_addr", {24'd0, bus_q[0].a}, {24'd0, a});
      if (is_wr) check_eq("bus_dwrite", {16'd0, bus_q[0].d}, {16'd0, dh, dl});
      exp_first = bus_q[0].c + 1;
    end
    check_eq("tx_latency", first_tx_cyc, exp_first);
    if (is_wr) begin
      if (op[1]) ref_mem[a][15:8] = dh;
      if (op[0]) ref_mem[a][7:0] = dl;
    end
  endtask

  initial begin
    logic [7:0] op;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = {8'(i), ~8'(i)};
      slave_mem[i] = {8'(i), ~8'(i)};
    end
    ref_mem[8'h14] = 16'hABCD;
    slave_mem[8'h14] = 16'hABCD;
    ref_mem[8'h10] = 16'h0007;
    slave_mem[8'h10] = 16'h0007;

    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_bus", {15'd0, sel, r, w, addr, dwrite}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_cmd(8'h81, 8'h00, 8'h12, 8'h34, 0, 0);
    do_cmd(8'h00, 8'h14, 8'h00, 8'h00, 0, 0);
    do_cmd(8'h40, 8'h00, 8'h00, 8'h00, 0, 0);
    do_cmd(8'h00, 8'h10, 8'h00, 8'h00, 0, 0);
    do_cmd(8'h00, 8'h08, 8'h00, 8'h00, 0, 10);
    do_cmd(8'h83, 8'h22, 8'h00, 8'h0F, 5, 0);

    // Reset in the middle of a write command.
    bus_q.delete();
    tx_q.delete();
    send_byte(8'h83, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_bus", {15'd0, sel, r, w, addr, dwrite}, 32'd0);
    check_eq("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_eq("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("midrst_no_bus", bus_q.size(), 0);
    check_eq("midrst_no_tx", tx_q.size(), 0);
    do_cmd(8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    // Randomized mix of reads, writes and illegal opcodes.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0, 1: op = 8'h00;
        2, 3: op = 8'h80 | 8'($urandom_range(0, 3));
        default: begin
          op = 8'($urandom_range(1, 255));
          while (op >= 8'h80 && op <= 8'h83) op = 8'($urandom_range(1, 255));
        end
      endcase
      do_cmd(op, 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
